// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
// Parameter defaults live here so the top and the scoreboard agree.
package regfile_pkg;

  localparam int BYP_NONE          = 0;
  localparam int BYP_WRITE_THROUGH = 1;

  localparam int DEF_ZERO_REG = 31;
  localparam int DEF_DATA_W   = 64;
  localparam int DEF_NREGS    = 32;

  // Address width for n entries; evaluated at elaboration time.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits for long-latency writes (loads).
// A set and a clear of the same register in one cycle leaves it busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS    = DEF_NREGS,
  parameter int ZERO_REG = DEF_ZERO_REG,
  localparam int AW      = clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREGS-1:0] clr,
  input  logic             set_en,
  input  logic [AW-1:0]    set_addr,
  output logic [NREGS-1:0] busy
);

  logic [NREGS-1:0] busy_next;

  always_comb begin
    busy_next = busy & ~clr;
    if (set_en && (set_addr != AW'(ZERO_REG)) && (int'(set_addr) < NREGS))
      busy_next[set_addr] = 1'b1;
    // The zero register has no pending writes by definition.
    busy_next[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

endmodule

// File: rtl/regfile_mp.sv
// N-read / M-write register file with hardwired zero register, optional
// same-cycle write-through forwarding and a load busy scoreboard.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NREGS    = DEF_NREGS,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS   = BYP_WRITE_THROUGH,
  parameter int RD_DELAY = 3,
  localparam int AW      = clog2(NREGS)
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [NRD*AW-1:0]     RA,
  output logic [NRD*DATA_W-1:0] BusR,
  output logic [NRD-1:0]        RdBusy,
  input  logic [NWR-1:0]        WrEn,
  input  logic [NWR*AW-1:0]     WrAddr,
  input  logic [NWR*DATA_W-1:0] WrData,
  input  logic                  SetBusyEn,
  input  logic [AW-1:0]         SetBusyAddr
);

  logic [DATA_W-1:0] rd_array [NREGS];
  logic [NREGS-1:0]  wr_hit;
  logic [NREGS-1:0]  busy;

  // Storage: one entry per register except the zero register, which has no flop.
  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    if (r == ZERO_REG) begin : g_zero
      assign wr_hit[r]   = 1'b0;
      assign rd_array[r] = '0;
    end else begin : g_store
      logic              hit;
      logic [DATA_W-1:0] val;
      logic [DATA_W-1:0] q;

      // Later ports override earlier ones, so the highest index wins a conflict.
      always_comb begin
        hit = 1'b0;
        val = '0;
        for (int j = 0; j < NWR; j++) begin
          if (WrEn[j] && (WrAddr[j*AW +: AW] == AW'(r))) begin
            hit = 1'b1;
            val = WrData[j*DATA_W +: DATA_W];
          end
        end
      end

      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)    q <= '0;
        else if (hit) q <= val;
      end

      assign wr_hit[r]   = hit;
      assign rd_array[r] = q;
    end
  end

  regfile_scoreboard #(
    .NREGS    (NREGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (Clk),
    .rst      (Reset),
    .clr      (wr_hit),
    .set_en   (SetBusyEn),
    .set_addr (SetBusyAddr),
    .busy     (busy)
  );

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]     addr;
    logic              valid;
    logic              byp_hit;
    logic [DATA_W-1:0] byp_val;
    logic              use_byp;

    assign addr  = RA[i*AW +: AW];
    assign valid = (addr != AW'(ZERO_REG)) && (int'(addr) < NREGS);

    always_comb begin
      byp_hit = 1'b0;
      byp_val = '0;
      for (int j = 0; j < NWR; j++) begin
        if (WrEn[j] && (WrAddr[j*AW +: AW] == addr)) begin
          byp_hit = 1'b1;
          byp_val = WrData[j*DATA_W +: DATA_W];
        end
      end
    end

    assign use_byp = (BYPASS == BYP_WRITE_THROUGH) && byp_hit;

    // RD_DELAY only shapes behavioural models; this read path is zero-delay.
    if (RD_DELAY >= 0) begin : g_out
      assign BusR[i*DATA_W +: DATA_W] = (Reset || !valid) ? '0 :
                                        use_byp ? byp_val : rd_array[addr];
      assign RdBusy[i] = !Reset && valid && !use_byp && busy[addr];
    end
  end

endmodule
